// File: rtl/sdp_ram_fifo_ctrl_if.sv
// rtl/sdp_ram_fifo_ctrl_if.sv - producer/consumer streams and RAM port bundle for the SDP RAM FIFO controller
interface sdp_ram_fifo_ctrl_if #(
  parameter int AW = 10,
  parameter int DW = 4
);
  logic          WR_VALID;
  logic          WR_READY;
  logic [DW-1:0] WR_DATA;
  logic          RD_VALID;
  logic          RD_READY;
  logic [DW-1:0] RD_DATA;
  logic [AW-1:0] RAM_ADDRA;
  logic          RAM_WEA;
  logic [DW-1:0] RAM_DIN;
  logic [AW-1:0] RAM_ADDRB;
  logic [DW-1:0] RAM_DOUT;
  logic [AW+1:0] COUNT;
  logic          FULL;
  logic          EMPTY;

  // Controller side
  modport slave (
    input  WR_VALID, WR_DATA, RD_READY, RAM_DOUT,
    output WR_READY, RD_VALID, RD_DATA, RAM_ADDRA, RAM_WEA, RAM_DIN,
           RAM_ADDRB, COUNT, FULL, EMPTY
  );

  // Producer / consumer / RAM side
  modport master (
    output WR_VALID, WR_DATA, RD_READY, RAM_DOUT,
    input  WR_READY, RD_VALID, RD_DATA, RAM_ADDRA, RAM_WEA, RAM_DIN,
           RAM_ADDRB, COUNT, FULL, EMPTY
  );
endinterface

// File: rtl/sdp_ram_fifo_ctrl.sv
// rtl/sdp_ram_fifo_ctrl.sv - FWFT FIFO controller over an external registered-read simple-dual-port RAM
module sdp_ram_fifo_ctrl #(
  parameter int AW = 10,
  parameter int DW = 4
) (
  input  logic                CLK,
  input  logic                RST_N,
  sdp_ram_fifo_ctrl_if.slave  bus
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          pend;
  logic [1:0]    ob_cnt;
  logic [DW-1:0] ob0;
  logic [DW-1:0] ob1;

  logic [AW:0]   ram_cnt;
  logic          wr_ready;
  logic          push;
  logic          rd_valid;
  logic          pop;
  logic          fetch;
  logic [2:0]    occ_after;
  logic [1:0]    ob_base;
  logic [1:0]    ob_cnt_nxt;
  logic [DW-1:0] ob0_nxt;
  logic [DW-1:0] ob1_nxt;

  assign ram_cnt  = wptr - rptr;
  assign wr_ready = (ram_cnt != DEPTH) && RST_N;
  assign push     = bus.WR_VALID && wr_ready;
  assign rd_valid = (ob_cnt != 2'd0);
  assign pop      = rd_valid && bus.RD_READY;

  // Occupancy the output buffer would have next cycle before any new fetch lands
  assign occ_after = {1'b0, ob_cnt} + {2'b00, pend} - {2'b00, pop};
  assign fetch     = (ram_cnt != '0) && (occ_after <= 3'd1);

  assign ob_base    = ob_cnt - {1'b0, pop};
  assign ob_cnt_nxt = ob_base + {1'b0, pend};

  // Shift on pop first, then land the returning RAM word in the first free slot
  always_comb begin
    ob0_nxt = pop ? ob1 : ob0;
    ob1_nxt = ob1;
    if (pend) begin
      if (ob_base == 2'd0) begin
        ob0_nxt = bus.RAM_DOUT;
      end else begin
        ob1_nxt = bus.RAM_DOUT;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr   <= '0;
      rptr   <= '0;
      pend   <= 1'b0;
      ob_cnt <= 2'd0;
      ob0    <= '0;
      ob1    <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (fetch) begin
        rptr <= rptr + 1'b1;
      end
      pend   <= fetch;
      ob_cnt <= ob_cnt_nxt;
      ob0    <= ob0_nxt;
      ob1    <= ob1_nxt;
    end
  end

  assign bus.WR_READY  = wr_ready;
  assign bus.FULL      = !wr_ready;
  assign bus.RD_VALID  = rd_valid;
  assign bus.EMPTY     = !rd_valid;
  assign bus.RD_DATA   = ob0;
  assign bus.RAM_ADDRA = wptr[AW-1:0];
  assign bus.RAM_WEA   = push;
  assign bus.RAM_DIN   = bus.WR_DATA;
  assign bus.RAM_ADDRB = rptr[AW-1:0];
  assign bus.COUNT     = {1'b0, ram_cnt} + {{(AW+1){1'b0}}, pend} + {{AW{1'b0}}, ob_cnt};

endmodule

// File: tb/tb_sdp_ram_fifo_ctrl.sv
// tb/tb_sdp_ram_fifo_ctrl.sv - directed and scoreboarded bench for sdp_ram_fifo_ctrl with a behavioural RAM
module tb_sdp_ram_fifo_ctrl;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  sdp_ram_fifo_ctrl_if #(.AW(10), .DW(4)) bus ();

  sdp_ram_fifo_ctrl #(.AW(10), .DW(4)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  logic [3:0] mem [1024];
  always @(posedge CLK) begin
    if (bus.RAM_WEA) mem[bus.RAM_ADDRA] <= bus.RAM_DIN;
    bus.RAM_DOUT <= mem[bus.RAM_ADDRB];
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard of accepted writes; pops are checked against it
  logic [3:0] sb [$];
  int         tot_push = 0;
  logic [9:0] prev_a = '0;
  logic [9:0] prev_b = '0;
  bit         wrap_a = 1'b0;
  bit         wrap_b = 1'b0;

  always @(negedge CLK) begin
    if (!RST_N) begin
      sb.delete();
    end else begin
      if (bus.RD_VALID && bus.RD_READY) begin
        if (sb.size() == 0) chk("pop_unexpected", 32'(sb.size()), 32'd1);
        else chk("pop_data", 32'(bus.RD_DATA), 32'(sb.pop_front()));
      end
      if (bus.WR_VALID && bus.WR_READY) begin
        sb.push_back(bus.WR_DATA);
        tot_push++;
      end
      if (bus.RAM_WEA) begin
        if (prev_a == 10'd1023 && bus.RAM_ADDRA == 10'd0) wrap_a = 1'b1;
        prev_a = bus.RAM_ADDRA;
      end
      if (prev_b == 10'd1023 && bus.RAM_ADDRB == 10'd0) wrap_b = 1'b1;
      prev_b = bus.RAM_ADDRB;
    end
  end

  typedef struct {
    logic       wv;
    logic [3:0] wd;
    logic       rr;
    logic       rv;
    logic [3:0] rd;
    logic [11:0] cnt;
    logic       wrdy;
    logic       wea;
    logic [9:0] addra;
  } vec_t;

  vec_t vt [10];

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    bus.WR_VALID = 1'b0;
    bus.RD_READY = 1'b0;
    @(negedge CLK);
    next_cycle();
    RST_N = 1'b1;
  endtask

  initial begin
    int acc;
    int pops;
    int base_push;
    bit done;

    //            wv   wd    rr   rv   rd    cnt  wrdy wea  addra
    vt[0] = '{1'b1, 4'h5, 1'b0, 1'b0, 4'h0, 12'd1 - 12'd1, 1'b1, 1'b1, 10'd0};
    vt[1] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 12'd1, 1'b1, 1'b0, 10'd1};
    vt[2] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 12'd1, 1'b1, 1'b0, 10'd1};
    vt[3] = '{1'b0, 4'h0, 1'b0, 1'b1, 4'h5, 12'd1, 1'b1, 1'b0, 10'd1};
    vt[4] = '{1'b1, 4'h9, 1'b1, 1'b1, 4'h5, 12'd1, 1'b1, 1'b1, 10'd1};
    vt[5] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 12'd1, 1'b1, 1'b0, 10'd2};
    vt[6] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 12'd1, 1'b1, 1'b0, 10'd2};
    vt[7] = '{1'b0, 4'h0, 1'b0, 1'b1, 4'h9, 12'd1, 1'b1, 1'b0, 10'd2};
    vt[8] = '{1'b0, 4'h0, 1'b1, 1'b1, 4'h9, 12'd1, 1'b1, 1'b0, 10'd2};
    vt[9] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 12'd0, 1'b1, 1'b0, 10'd2};

    bus.WR_VALID = 1'b1;
    bus.WR_DATA  = 4'h7;
    bus.RD_READY = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_rd_valid", 32'(bus.RD_VALID), 32'd0);
    chk("rst_rd_data", 32'(bus.RD_DATA), 32'd0);
    chk("rst_wea", 32'(bus.RAM_WEA), 32'd0);
    chk("rst_wr_ready", 32'(bus.WR_READY), 32'd0);
    chk("rst_count", 32'(bus.COUNT), 32'd0);
    chk("rst_empty", 32'(bus.EMPTY), 32'd1);
    chk("rst_full", 32'(bus.FULL), 32'd1);
    next_cycle();
    bus.WR_VALID = 1'b0;
    bus.RD_READY = 1'b0;
    RST_N = 1'b1;

    // Single push latency and push+pop interleave
    for (int i = 0; i < 10; i++) begin
      bus.WR_VALID = vt[i].wv;
      bus.WR_DATA  = vt[i].wd;
      bus.RD_READY = vt[i].rr;
      @(negedge CLK);
      chk($sformatf("vec%0d_rd_valid", i), 32'(bus.RD_VALID), 32'(vt[i].rv));
      chk($sformatf("vec%0d_rd_data", i), 32'(bus.RD_DATA), 32'(vt[i].rd));
      chk($sformatf("vec%0d_count", i), 32'(bus.COUNT), 32'(vt[i].cnt));
      chk($sformatf("vec%0d_wr_ready", i), 32'(bus.WR_READY), 32'(vt[i].wrdy));
      chk($sformatf("vec%0d_wea", i), 32'(bus.RAM_WEA), 32'(vt[i].wea));
      chk($sformatf("vec%0d_addra", i), 32'(bus.RAM_ADDRA), 32'(vt[i].addra));
      next_cycle();
    end

    // Continuous stream 0..F: first word after 3 cycles, then one per cycle
    for (int k = 0; k < 20; k++) begin
      bus.WR_VALID = (k < 16);
      bus.WR_DATA  = 4'(k);
      bus.RD_READY = 1'b1;
      @(negedge CLK);
      chk($sformatf("stream%0d_rd_valid", k), 32'(bus.RD_VALID), 32'(k >= 3 && k < 19));
      if (k >= 3 && k < 19) chk($sformatf("stream%0d_rd_data", k), 32'(bus.RD_DATA), 32'(k - 3));
      next_cycle();
    end
    bus.WR_VALID = 1'b0;
    bus.RD_READY = 1'b0;

    // Fill to capacity with no reads
    do_reset();
    acc = 0;
    for (int n = 0; n < 1100; n++) begin
      bus.WR_VALID = 1'b1;
      bus.WR_DATA  = 4'(n);
      @(negedge CLK);
      if (!bus.WR_READY) break;
      acc++;
      next_cycle();
    end
    next_cycle();
    bus.WR_VALID = 1'b0;
    chk("fill_accepted", 32'(acc), 32'd1026);
    next_cycle();
    @(negedge CLK);
    chk("fill_count", 32'(bus.COUNT), 32'd1026);
    chk("fill_full", 32'(bus.FULL), 32'd1);
    chk("fill_empty", 32'(bus.EMPTY), 32'd0);
    next_cycle();
    bus.RD_READY = 1'b1;
    @(negedge CLK);
    chk("fill_pop_data", 32'(bus.RD_DATA), 32'd0);
    next_cycle();
    bus.RD_READY = 1'b0;
    @(negedge CLK);
    chk("fill_wr_ready_back", 32'(bus.WR_READY), 32'd1);
    chk("fill_count_after_pop", 32'(bus.COUNT), 32'd1025);
    next_cycle();
    bus.RD_READY = 1'b1;
    pops = 0;
    for (int n = 0; n < 1100; n++) begin
      @(negedge CLK);
      if (bus.EMPTY) break;
      pops++;
      next_cycle();
    end
    next_cycle();
    bus.RD_READY = 1'b0;
    chk("drain_pops", 32'(pops), 32'd1025);
    chk("drain_count", 32'(bus.COUNT), 32'd0);

    // Random traffic across the address wrap
    base_push = tot_push;
    done = 1'b0;
    for (int n = 0; n < 20000; n++) begin
      bus.WR_VALID = ((tot_push - base_push) < 3000) && ($urandom_range(3) != 0);
      bus.WR_DATA  = 4'($urandom);
      bus.RD_READY = ($urandom_range(2) != 0);
      next_cycle();
      if ((tot_push - base_push) >= 3000 && sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    bus.WR_VALID = 1'b0;
    bus.RD_READY = 1'b0;
    chk("rand_done", 32'(done), 32'd1);
    chk("rand_wrap_addra", 32'(wrap_a), 32'd1);
    chk("rand_wrap_addrb", 32'(wrap_b), 32'd1);
    next_cycle();
    next_cycle();

    // Reset with a fetch in flight and the output buffer occupied
    for (int i = 1; i <= 5; i++) begin
      bus.WR_VALID = 1'b1;
      bus.WR_DATA  = 4'(i);
      next_cycle();
    end
    bus.WR_VALID = 1'b0;
    repeat (4) next_cycle();
    @(negedge CLK);
    chk("mid_count_before", 32'(bus.COUNT), 32'd5);
    next_cycle();
    bus.RD_READY = 1'b1;
    next_cycle();
    bus.RD_READY = 1'b0;
    @(negedge CLK);
    chk("mid_count_inflight", 32'(bus.COUNT), 32'd4);
    chk("mid_rd_data", 32'(bus.RD_DATA), 32'd2);
    #1;
    RST_N = 1'b0;
    #1;
    chk("mid_rst_rd_valid", 32'(bus.RD_VALID), 32'd0);
    chk("mid_rst_count", 32'(bus.COUNT), 32'd0);
    chk("mid_rst_wr_ready", 32'(bus.WR_READY), 32'd0);
    @(negedge CLK);
    next_cycle();
    RST_N = 1'b1;
    bus.WR_VALID = 1'b1;
    bus.WR_DATA  = 4'hA;
    @(negedge CLK);
    chk("post_rst_addra", 32'(bus.RAM_ADDRA), 32'd0);
    chk("post_rst_wea", 32'(bus.RAM_WEA), 32'd1);
    next_cycle();
    bus.WR_VALID = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge CLK);
    chk("post_rst_rd_valid", 32'(bus.RD_VALID), 32'd1);
    chk("post_rst_rd_data", 32'(bus.RD_DATA), 32'hA);
    next_cycle();
    bus.RD_READY = 1'b1;
    next_cycle();
    bus.RD_READY = 1'b0;
    next_cycle();

    // Push and pop together while a single entry is held
    bus.WR_VALID = 1'b1;
    bus.WR_DATA  = 4'h3;
    next_cycle();
    bus.WR_VALID = 1'b0;
    for (int j = 0; j < 2; j++) begin
      @(negedge CLK);
      chk($sformatf("hold_pre%0d_count", j), 32'(bus.COUNT), 32'd1);
      next_cycle();
    end
    for (int i = 0; i < 10; i++) begin
      bus.WR_VALID = 1'b1;
      bus.WR_DATA  = 4'(i + 6);
      bus.RD_READY = 1'b1;
      @(negedge CLK);
      chk($sformatf("hold%0d_rd_valid", i), 32'(bus.RD_VALID), 32'd1);
      chk($sformatf("hold%0d_count", i), 32'(bus.COUNT), 32'd1);
      next_cycle();
      bus.WR_VALID = 1'b0;
      bus.RD_READY = 1'b0;
      for (int j = 0; j < 2; j++) begin
        @(negedge CLK);
        chk($sformatf("hold%0d_idle%0d_count", i, j), 32'(bus.COUNT), 32'd1);
        next_cycle();
      end
    end
    bus.RD_READY = 1'b1;
    @(negedge CLK);
    chk("hold_last_data", 32'(bus.RD_DATA), 32'hF);
    next_cycle();
    bus.RD_READY = 1'b0;
    @(negedge CLK);
    chk("hold_end_empty", 32'(bus.EMPTY), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
